// File: rtl/monitor_sched_pkg.sv
// Shared types and constants for the report scheduler: FSM states, id width
// helper and the drop counter width.
package monitor_sched_pkg;

    typedef enum logic [1:0] {IDLE, RST, RUN, DRAIN} sched_state_e;

    localparam int DROP_W          = 16;
    localparam int NUM_REPORTS_DEF = 36;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NUM_REPORTS_DEF);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of vec_i at or after ptr_i,
// wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N    = 36,
    parameter int ID_W = 6
) (
    input  logic [N-1:0]    vec_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o
);

    logic [ID_W:0] k;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        k       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (k >= (ID_W+1)'(N)) k = k - (ID_W+1)'(N);
            if (vec_i[k[ID_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = k[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/monitor_report_scheduler.sv
// Sequences one automata stage: feeds trace symbols, captures report pulses
// into a pending bitmap and serialises them round-robin onto one channel.
module monitor_report_scheduler
    import monitor_sched_pkg::*;
#(
    parameter int NUM_REPORTS = 36,
    parameter int SYM_W       = 8,
    parameter int TS_W        = 32,
    parameter int REPORT_LAT  = 1,
    parameter int RST_CYCLES  = 2,
    parameter int HIGH_WATER  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             sym_valid,
    output logic                             sym_ready,
    input  logic [SYM_W-1:0]                 sym_in,
    output logic                             run,
    output logic [SYM_W-1:0]                 top_symbols,
    output logic                             auto_reset,
    input  logic [NUM_REPORTS-1:0]           rep_in,
    output logic                             rpt_valid,
    input  logic                             rpt_ready,
    output logic [id_width(NUM_REPORTS)-1:0] rpt_id,
    output logic [TS_W-1:0]                  rpt_ts,
    output logic [DROP_W-1:0]                drop_cnt,
    output logic                             busy,
    output logic                             done
);

    localparam int RID_W = id_width(NUM_REPORTS);
    localparam int CNT_W = $clog2(NUM_REPORTS + 1);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REPORTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REPORTS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [CNT_W-1:0]  b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W+1)'(b);
        return s[DROP_W] ? '1 : s[DROP_W-1:0];
    endfunction

    sched_state_e           state_q;
    logic [RC_W-1:0]        rcnt_q;
    logic [TS_W-1:0]        idx_q, run_ts_q;
    logic [REPORT_LAT-1:0]  rs_vld_q;
    logic [TS_W-1:0]        rs_ts_q [REPORT_LAT];
    logic [NUM_REPORTS-1:0] pend_q, pend_d;
    logic [TS_W-1:0]        ts_q [NUM_REPORTS];
    logic [RID_W-1:0]       ptr_q, gnt_id;
    logic [CNT_W-1:0]       pcnt_q;
    logic                   gnt_found, grant, xfer, rep_sample, pipe_empty;
    logic [NUM_REPORTS-1:0] gnt_mask, cap_set, drop_mask;
    logic [TS_W-1:0]        rep_ts;

    rr_pick #(.N(NUM_REPORTS), .ID_W(RID_W)) u_pick (
        .vec_i  (pend_q),
        .ptr_i  (ptr_q),
        .found_o(gnt_found),
        .idx_o  (gnt_id)
    );

    assign rep_sample = rs_vld_q[REPORT_LAT-1];
    assign rep_ts     = rs_ts_q[REPORT_LAT-1];
    assign sym_ready  = (state_q == RUN) && (int'(pcnt_q) < HIGH_WATER);
    assign xfer       = sym_valid && sym_ready;
    assign busy       = (state_q != IDLE);
    assign grant      = gnt_found && (!rpt_valid || rpt_ready);
    assign pipe_empty = !run && (rs_vld_q == '0);

    // A bit granted this cycle frees its slot, so a same-cycle capture re-arms it.
    always_comb begin
        gnt_mask = '0;
        if (grant) gnt_mask[gnt_id] = 1'b1;
        cap_set   = rep_sample ? rep_in : '0;
        drop_mask = cap_set & pend_q & ~gnt_mask;
        pend_d    = (pend_q & ~gnt_mask) | (cap_set & ~drop_mask);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REPORTS; i++)
            if (cap_set[i] && !drop_mask[i]) ts_q[i] <= rep_ts;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            idx_q       <= '0;
            run_ts_q    <= '0;
            rs_vld_q    <= '0;
            for (int k = 0; k < REPORT_LAT; k++) rs_ts_q[k] <= '0;
            pend_q      <= '0;
            pcnt_q      <= '0;
            ptr_q       <= '0;
            run         <= 1'b0;
            top_symbols <= '0;
            auto_reset  <= 1'b0;
            rpt_valid   <= 1'b0;
            rpt_id      <= '0;
            rpt_ts      <= '0;
            drop_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            run  <= xfer;
            if (xfer) begin
                top_symbols <= sym_in;
                run_ts_q    <= idx_q;
                idx_q       <= idx_q + TS_W'(1);
            end
            // Run-delay pipeline: each slot carries the index of its symbol.
            rs_vld_q[0] <= run;
            rs_ts_q[0]  <= run_ts_q;
            for (int k = 1; k < REPORT_LAT; k++) begin
                rs_vld_q[k] <= rs_vld_q[k-1];
                rs_ts_q[k]  <= rs_ts_q[k-1];
            end
            pend_q   <= pend_d;
            pcnt_q   <= popcount(pend_d);
            drop_cnt <= sat_add(drop_cnt, popcount(drop_mask));
            if (grant) begin
                rpt_valid <= 1'b1;
                rpt_id    <= gnt_id;
                rpt_ts    <= ts_q[gnt_id];
                ptr_q     <= (gnt_id == RID_W'(NUM_REPORTS - 1)) ? '0 : gnt_id + RID_W'(1);
            end else if (rpt_ready) begin
                rpt_valid <= 1'b0;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= RST;
                    auto_reset <= 1'b1;
                    rcnt_q     <= '0;
                    pend_q     <= '0;
                    pcnt_q     <= '0;
                    idx_q      <= '0;
                    drop_cnt   <= '0;
                    ptr_q      <= '0;
                end
                RST: if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                    auto_reset <= 1'b0;
                    state_q    <= RUN;
                end else begin
                    rcnt_q <= rcnt_q + RC_W'(1);
                end
                RUN: if (stop) state_q <= DRAIN;
                DRAIN: if (pipe_empty && (pend_q == '0) && !rpt_valid) begin
                    state_q <= IDLE;
                    done    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_report_scheduler.sv
// Directed bench for monitor_report_scheduler: queue of expected report
// events, popped as the DUT hands reports off on the output channel.
module tb_monitor_report_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, stop, sym_valid, rpt_ready;
    logic [7:0]  sym_in;
    logic [35:0] rep_in;
    logic        sym_ready, run, auto_reset, rpt_valid, busy, done;
    logic [7:0]  top_symbols;
    logic [5:0]  rpt_id;
    logic [31:0] rpt_ts;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_idx = 0;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] ts;
    } exp_t;
    exp_t sb[$];

    monitor_report_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_in     (sym_in),
        .run        (run),
        .top_symbols(top_symbols),
        .auto_reset (auto_reset),
        .rep_in     (rep_in),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_id     (rpt_id),
        .rpt_ts     (rpt_ts),
        .drop_cnt   (drop_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input int ts);
        exp_t e;
        e.id = 6'(id);
        e.ts = 32'(ts);
        sb.push_back(e);
    endtask

    // Offer one symbol (caller sits at a negedge), then play the stage's
    // report wires during the rep_sample cycle.
    task automatic send(input logic [7:0] s, input logic [35:0] bits);
        chk("sym_ready_pre", sym_ready, 1);
        sym_valid = 1'b1;
        sym_in    = s;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("run_pulse", run, 1);
        chk("top_symbols", top_symbols, s);
        exp_idx++;
        @(negedge clk);
        chk("run_one_cycle", run, 0);
        rep_in = bits;
        @(negedge clk);
        rep_in = '0;
    endtask

    // Scoreboard consumer: a handshake happens at the next posedge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!reset && rpt_valid && rpt_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $error("FAIL sb_unexpected: observed id=%0d ts=%0d expected none", rpt_id, rpt_ts);
            end else begin
                e = sb.pop_front();
                chk("sb_rpt_id", rpt_id, e.id);
                chk("sb_rpt_ts", rpt_ts, e.ts);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; sym_valid = 1'b0;
        rpt_ready = 1'b0; sym_in = '0; rep_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_auto_reset", auto_reset, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_top", top_symbols, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_sym_ready", sym_ready, 0);

        // Start: auto_reset for two cycles, then RUN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst1_auto", auto_reset, 1);
        chk("rst1_busy", busy, 1);
        chk("rst1_sym_ready", sym_ready, 0);
        @(negedge clk);
        chk("rst2_auto", auto_reset, 1);
        @(negedge clk);
        chk("run_auto", auto_reset, 0);
        chk("run_sym_ready", sym_ready, 1);
        chk("run_busy", busy, 1);

        send(8'h41, '0);
        send(8'h42, '0);
        send(8'h43, '0);

        // Single report at symbol index 3, held under backpressure
        push(5, 3);
        send(8'h44, 36'd1 << 5);
        @(negedge clk);
        chk("single_valid", rpt_valid, 1);
        chk("single_id", rpt_id, 5);
        chk("single_ts", rpt_ts, 3);
        repeat (4) begin
            @(negedge clk);
            chk("hold_valid", rpt_valid, 1);
            chk("hold_id", rpt_id, 5);
            chk("hold_ts", rpt_ts, 3);
        end
        rpt_ready = 1'b1;
        @(negedge clk);
        chk("single_cleared", rpt_valid, 0);

        // Report 7 moves the pointer to 8
        push(7, 4);
        send(8'h45, 36'd1 << 7);
        repeat (2) @(negedge clk);
        chk("ptr_setup_cleared", rpt_valid, 0);

        // Round robin from pointer 8: 30, 2, 7
        push(30, 5); push(2, 5); push(7, 5);
        send(8'h46, (36'd1 << 2) | (36'd1 << 7) | (36'd1 << 30));
        @(negedge clk);
        chk("rr_first", rpt_id, 30);
        @(negedge clk);
        chk("rr_second", rpt_id, 2);
        @(negedge clk);
        chk("rr_third", rpt_id, 7);
        chk("rr_third_valid", rpt_valid, 1);
        @(negedge clk);
        chk("rr_done_valid", rpt_valid, 0);
        chk("rr_sb_empty", sb.size(), 0);

        // Overflow: 9 occupies the output, then bit 4 arrives twice
        rpt_ready = 1'b0;
        push(9, 6); push(4, 7);
        send(8'h47, 36'd1 << 9);
        send(8'h48, 36'd1 << 4);
        chk("ovf_no_drop_yet", drop_cnt, 0);
        send(8'h49, 36'd1 << 4);
        chk("ovf_drop_one", drop_cnt, 1);
        chk("ovf_out_id", rpt_id, 9);
        chk("ovf_out_ts", rpt_ts, 6);
        force dut.drop_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.drop_cnt;
        @(negedge clk);
        chk("sat_preset", drop_cnt, 16'hFFFF);
        send(8'h4A, 36'd1 << 4);
        chk("sat_hold", drop_cnt, 16'hFFFF);
        rpt_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovf_drained_valid", rpt_valid, 0);
        chk("ovf_sb_empty", sb.size(), 0);

        // Backpressure: 9 reports, one in the output, 8 pending
        rpt_ready = 1'b0;
        for (int b = 10; b <= 18; b++) push(b, 10);
        send(8'h4B, 36'h1FF << 10);
        chk("bp_stall_a", sym_ready, 0);
        @(negedge clk);
        chk("bp_stall_b", sym_ready, 0);
        sym_valid = 1'b1;
        sym_in    = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_run", run, 0);
        end
        sym_valid = 1'b0;
        rpt_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", sym_ready, 1);
        repeat (10) @(negedge clk);
        chk("bp_drained_valid", rpt_valid, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Drain: pointer is 19, so 1, 3, 5 come out in order
        rpt_ready = 1'b0;
        push(1, 11); push(3, 11); push(5, 11);
        send(8'h4C, (36'd1 << 1) | (36'd1 << 3) | (36'd1 << 5));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_sym_ready", sym_ready, 0);
        chk("drain_not_done", done, 0);
        rpt_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("drain_done", done, 1);
        chk("drain_idle", busy, 0);
        chk("drain_sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // New session clears drop_cnt and the index
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s2_drop_clear", drop_cnt, 0);
        chk("s2_auto", auto_reset, 1);
        repeat (2) @(negedge clk);
        chk("s2_run", sym_ready, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s2_start_ignored", auto_reset, 0);
        chk("s2_still_busy", busy, 1);
        rpt_ready = 1'b0;
        exp_idx   = 0;
        send(8'h55, 36'd1 << 0);
        @(negedge clk);
        chk("s2_valid", rpt_valid, 1);
        chk("s2_id", rpt_id, 0);
        chk("s2_ts", rpt_ts, exp_idx - 1);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", rpt_valid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_top", top_symbols, 0);
        chk("areset_sym_ready", sym_ready, 0);
        chk("areset_auto", auto_reset, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_valid", rpt_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/monitor_report_scheduler.md
Name: monitor_report_scheduler

Overview:
- Sequences one automata stage cluster (the 8-bit symbol stream plus 36 report wires).
- Accepts trace symbols over a valid/ready handshake and drives the stage's run, reset and symbol inputs.
- Captures report pulses into a pending bitmap with a per-report symbol index.
- Serialises reports round-robin onto a single valid/ready report channel, and backpressures the trace source when too many reports are pending.

Parameters:
- NUM_REPORTS, 36, number of report wires from the stage.
- SYM_W, 8, symbol width.
- TS_W, 32, symbol-index counter width.
- REPORT_LAT, 1, cycles from a run pulse to its reports being valid on rep_in (range 1..4).
- RST_CYCLES, 2, cycles auto_reset is held after start.
- HIGH_WATER, 8, pending count at or above which symbol intake stalls.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begin a monitoring session
- stop  in  1  pulse; end the session after draining
- sym_valid  in  1  trace symbol valid
- sym_ready  out  1  trace symbol accepted
- sym_in  in  SYM_W  trace symbol
- run  out  1  stage run pulse
- top_symbols  out  SYM_W  symbol to stage
- auto_reset  out  1  stage reset
- rep_in  in  NUM_REPORTS  stage report wires
- rpt_valid  out  1  report event valid
- rpt_ready  in  1  report event consumed
- rpt_id  out  clog2(NUM_REPORTS)  report index
- rpt_ts  out  TS_W  symbol index at capture
- drop_cnt  out  16  saturating count of lost reports
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset values: all outputs 0; pending bitmap 0; symbol index 0; round-robin pointer 0; state IDLE.
- FSM IDLE:
  - sym_ready=0.
  - start -> RST: clear pending, index, drop_cnt and pointer.
- FSM RST:
  - auto_reset=1 for exactly RST_CYCLES cycles, then -> RUN.
  - stop is ignored in RST.
- FSM RUN:
  - sym_ready = (pending_cnt < HIGH_WATER).
  - A transfer (sym_valid&&sym_ready) registers top_symbols<=sym_in and run<=1 for the next cycle only. Otherwise run<=0 and top_symbols holds.
  - The index increments on each transfer and wraps modulo 2^TS_W.
  - stop -> DRAIN. A transfer in the same cycle as stop is still accepted.
- FSM DRAIN:
  - sym_ready=0.
  - -> IDLE when the run-delay pipeline is empty, pending==0 and rpt_valid==0. Pulse done on that transition.
- Capture:
  - run is delayed REPORT_LAT cycles to form rep_sample, which carries the index of its symbol.
  - When rep_sample=1, each set rep_in bit i sets pending[i] and stores ts[i].
  - If pending[i] is already set and i is not being granted this cycle: overflow. ts[i] keeps the old value, and drop_cnt increments once per dropped bit per cycle, saturating at 0xFFFF.
  - rep_in is ignored when rep_sample=0.
- Grant:
  - The output register loads when (!rpt_valid || rpt_ready) and pending!=0.
  - It selects the first set bit at or after the pointer, wrapping. It loads rpt_id and rpt_ts, clears that pending bit, and sets pointer = id+1 (wrap at NUM_REPORTS).
  - rpt_id and rpt_ts are held stable while rpt_valid && !rpt_ready.
  - One grant per cycle; back-to-back grants are allowed when rpt_ready stays high.
- Same-cycle capture and grant of the same id: the grant takes the old ts, and the new capture re-sets pending with the new ts. No drop is counted.
- pending_cnt is the popcount of the bitmap, registered. A one-cycle stall lag is acceptable; at most REPORT_LAT+1 extra captures occur past HIGH_WATER.
- start while not in IDLE is ignored.
- reset mid-operation: everything returns to its reset values immediately. auto_reset drops to 0, so the stage must also be reset by the system reset.

Decomposition:
- Package monitor_sched_pkg holds:
  - the state enum (IDLE, RST, RUN, DRAIN);
  - the ID_W = $clog2(NUM_REPORTS) function/constant;
  - the drop counter width constant (16).
- One sub-module, rr_pick: a combinational round-robin first-set finder (vector, pointer -> found, index).

Test Plan:
- Start then run: reset, start → auto_reset=1 for 2 cycles, then busy=1 and sym_ready=1. Send sym 0x41 → run=1 with top_symbols=0x41 exactly one cycle after acceptance.
- Single report: rep_in bit 5 high at rep_sample for symbol index 3 → rpt_valid with rpt_id=5, rpt_ts=3. rpt_ready held 0 for 4 cycles → outputs stable.
- Round-robin order: bits 2, 7 and 30 captured together, pointer=8 → ids emitted 30, 2, 7 on consecutive cycles with rpt_ready=1.
- Overflow: bit 4 captured twice with rpt_ready=0 → drop_cnt=1, rpt_ts equals the first index. Set drop_cnt to 0xFFFF by forcing, then another drop → stays 0xFFFF.
- Backpressure: 8 distinct bits pending, rpt_ready=0 → sym_ready=0 within 2 cycles. Release rpt_ready → sym_ready returns to 1 once the count drops below 8.
- Drain and async reset: stop with 3 pending → all 3 emitted, then done pulse and busy=0. Separately, assert reset mid-RUN between clock edges → outputs 0 immediately.
